pa_sahbl_arb: RTL and testbench
===============================

# pa_sahbl_arb

Two-requester arbiter and transfer sequencer for the system AHB-Lite master port. It shares one AHB-Lite bus between the BMU instruction bus (ibus) and data bus (dbus). It drives the address phase, tracks the single outstanding data phase, and returns grant, completion and error status to the owning requester. It sits between the BMU and the pad-side AHB-Lite interface inside the system bus unit.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive dbus grants allowed while ibus waits before ibus is forced to win (1..7).

Ports:
- forever_cpuclk  in  1  clock (one clock domain)
- cpurst_b  in  1  asynchronous, active-low reset
- ibus_req / ibus_addr / ibus_size / ibus_prot  in  1/32/2/4  instruction read request; held until grant
- dbus_req / dbus_addr / dbus_size / dbus_prot / dbus_write / dbus_lock  in  1/32/2/4/1/1  data request; held until grant
- dbus_wdata  in  32  write data, valid in the grant cycle
- ibus_grnt, dbus_grnt  out  1  address phase accepted
- ibus_trans_cmplt, dbus_trans_cmplt  out  1  data phase finished
- ibus_acc_err, dbus_acc_err  out  1  qualifies cmplt; the slave returned ERROR
- ibus_data, dbus_data  out  32  hrdata passthrough, valid with cmplt
- haddr / htrans / hwrite / hsize / hprot / hlock / hburst  out  32/2/1/3/4/1/3  AHB-Lite address phase
- hwdata  out  32  registered write data
- hrdata / hready / hresp  in  32/1/1  AHB-Lite slave response
- arb_idle  out  1  no request pending and no data phase outstanding

## Operation
- Single transfers only: htrans is IDLE(00) or NONSEQ(10); hburst is always SINGLE(000); hsize is {1'b0,size}; ibus hwrite is 0.
- Winner selection, in priority order:
  1. a held address phase keeps its owner;
  2. if lock_hold is set, dbus only;
  3. if starve_cnt is at STARVE_MAX and ibus_req is high, ibus;
  4. otherwise dbus over ibus.
- Address-phase outputs are a combinational mux of the winner's request. When there is no winner: htrans=IDLE and haddr holds its last value.
- grnt(winner) = winner valid & hready & ~err_block.
- On grant, data-phase registers load: dp_vld=1, dp_owner, dp_write. For a dbus write, hwdata <= dbus_wdata.
- ap_hold is set when htrans=NONSEQ and hready=0; it stores the owner and clears on grant.
- trans_cmplt(dp_owner) = dp_vld & hready. dp_vld clears on cmplt unless a new grant happens in the same cycle (back-to-back pipelining).
- Error handling is two-cycle:
  - Cycle 1 (hresp=1, hready=0): err_block forces htrans=IDLE and clears ap_hold, so the pending address is cancelled and the requester re-arbitrates.
  - Cycle 2 (hresp=1, hready=1): cmplt and acc_err go to dp_owner; err_block still suppresses any grant.
  - Normal arbitration resumes the following cycle.
- starve_cnt (3 bits):
  - increments on a dbus grant while ibus_req=1, saturating at STARVE_MAX;
  - clears on an ibus grant, or whenever ibus_req=0.
- Lock:
  - lock_hold is set on a dbus grant with dbus_lock=1; hlock = lock_hold | (winner dbus & dbus_lock).
  - lock_hold clears on a dbus grant with dbus_lock=0, or when dbus_req=0 and dp_vld=0.
- arb_idle = ~ibus_req & ~dbus_req & ~dp_vld.

## Timing
- Reset values:
  - htrans=IDLE, haddr=0, hwdata=0, hlock=0, all grnt/cmplt/acc_err=0;
  - arb_idle=1, dp_vld=0, ap_hold=0, err_block=0, lock_hold=0, starve_cnt=0.
- Grant is issued in the request cycle when the bus is free and hready=1 (0-cycle latency).
- With a zero-wait slave, cmplt comes 1 cycle after grant. Each wait state adds 1 cycle.
- Back-to-back: a grant and the previous cmplt may occur in the same cycle.
- Reset asserted mid-transfer drops all state immediately. No cmplt is issued for the aborted transfer.

## Configuration
- PA_SAHBL_ARB_STARVE_EN defined: the starvation counter and forced-ibus rule are compiled in.
- Not defined: starve_cnt is removed and the arbiter uses strict dbus-over-ibus priority. STARVE_MAX is then ignored.

## Structure
- Package pa_sahbl_pkg holds:
  - HTRANS_IDLE and HTRANS_NONSEQ constants;
  - HBURST_SINGLE;
  - the owner encoding (OWNER_IBUS=0, OWNER_DBUS=1).
- One sub-module, pa_sahbl_arb_dp: the data-phase tracker (dp_vld, dp_owner, hwdata register, err_block, cmplt/acc_err steering).
- Arbitration, ap_hold, lock and starvation logic stay in the top.

## Test plan
- Both requests are high in cycle 0 with hready=1 -> dbus_grnt in cycle 0, dbus_trans_cmplt in cycle 1, ibus_grnt in cycle 1, ibus_trans_cmplt in cycle 2.
- dbus write with addr 0x2000_0010 and wdata 0xDEAD_BEEF, slave inserts 2 wait states -> htrans=NONSEQ held for 3 cycles, hwdata=0xDEAD_BEEF in the data phase, cmplt on the 3rd data-phase cycle.
- Continuous dbus_req and ibus_req with STARVE_MAX=4 and the macro on -> ibus wins after 4 dbus grants. Macro off -> ibus is never granted.
- ibus read, slave returns ERROR (hresp=1,hready=0 then hresp=1,hready=1) while a dbus address is pending -> htrans=IDLE in both error cycles, then ibus_acc_err=1 with ibus_trans_cmplt; dbus is granted 1 cycle later.
- dbus_lock=1 on two transfers while ibus_req=1 -> hlock=1 and no ibus_grnt until the dbus grant with lock=0.
- cpurst_b asserted during a waited data phase -> all outputs reach reset values asynchronously; no cmplt is seen after reset release.

Source files
------------

// File: rtl/pa_sahbl_pkg.sv
// pa_sahbl_pkg: shared constants and types for the system AHB-Lite arbiter.
//   HTRANS / HBURST encodings, requester owner encoding and the
//   address-phase request bundle used by the winner mux.
package pa_sahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic {
        OWNER_IBUS = 1'b0,
        OWNER_DBUS = 1'b1
    } owner_e;

    // Address-phase fields of one requester.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  prot;
        logic        write;
    } ahb_req_t;

endpackage

// File: rtl/pa_sahbl_arb_dp.sv
// pa_sahbl_arb_dp: data-phase tracker for the single outstanding AHB-Lite
// transfer.
//   i_clk, i_rst_n     clock, async active-low reset
//   i_grnt, i_owner    address phase accepted this cycle and by whom
//   i_wr_load, i_wdata dbus write accepted: capture write data
//   i_hready, i_hresp  slave response
//   o_dp_vld           a data phase is outstanding
//   o_err_block        slave is signalling ERROR: suppress new address phases
//   o_hwdata           registered write data
//   o_*_cmplt/acc_err  completion and error steered to the data-phase owner
module pa_sahbl_arb_dp
    import pa_sahbl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_grnt,
    input  owner_e      i_owner,
    input  logic        i_wr_load,
    input  logic [31:0] i_wdata,
    input  logic        i_hready,
    input  logic        i_hresp,
    output logic        o_dp_vld,
    output logic        o_err_block,
    output logic [31:0] o_hwdata,
    output logic        o_ibus_cmplt,
    output logic        o_dbus_cmplt,
    output logic        o_ibus_acc_err,
    output logic        o_dbus_acc_err
);

    logic        r_dp_vld;
    owner_e      r_dp_owner;
    logic [31:0] r_hwdata;
    logic        w_cmplt;

    assign w_cmplt     = r_dp_vld & i_hready;
    // Both ERROR cycles see hresp=1; blocking is combinational so the
    // first cycle already drives IDLE.
    assign o_err_block = r_dp_vld & i_hresp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dp_vld   <= 1'b0;
            r_dp_owner <= OWNER_IBUS;
            r_hwdata   <= '0;
        end else begin
            // A grant in the completing cycle keeps the phase valid (pipelined).
            if (i_grnt) begin
                r_dp_vld   <= 1'b1;
                r_dp_owner <= i_owner;
            end else if (w_cmplt) begin
                r_dp_vld   <= 1'b0;
            end
            if (i_wr_load)
                r_hwdata <= i_wdata;
        end
    end

    assign o_dp_vld       = r_dp_vld;
    assign o_hwdata       = r_hwdata;
    assign o_ibus_cmplt   = w_cmplt & (r_dp_owner == OWNER_IBUS);
    assign o_dbus_cmplt   = w_cmplt & (r_dp_owner == OWNER_DBUS);
    assign o_ibus_acc_err = o_ibus_cmplt & i_hresp;
    assign o_dbus_acc_err = o_dbus_cmplt & i_hresp;

endmodule

// File: rtl/pa_sahbl_arb.sv
// pa_sahbl_arb: ibus/dbus arbiter and single-transfer sequencer for the
// system AHB-Lite master port.
//   forever_cpuclk, cpurst_b     clock, async active-low reset
//   ibus_*/dbus_*                requests (held until grant) and responses
//   h*                           AHB-Lite master signals
//   arb_idle                     nothing pending, nothing outstanding
// Optional feature macro PA_SAHBL_ARB_STARVE_EN: starvation counter that
// forces an ibus win after STARVE_MAX consecutive dbus grants. Without it
// dbus has strict priority and STARVE_MAX has no effect.
module pa_sahbl_arb
    import pa_sahbl_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        ibus_req,
    input  logic [31:0] ibus_addr,
    input  logic [1:0]  ibus_size,
    input  logic [3:0]  ibus_prot,
    input  logic        dbus_req,
    input  logic [31:0] dbus_addr,
    input  logic [1:0]  dbus_size,
    input  logic [3:0]  dbus_prot,
    input  logic        dbus_write,
    input  logic        dbus_lock,
    input  logic [31:0] dbus_wdata,
    output logic        ibus_grnt,
    output logic        dbus_grnt,
    output logic        ibus_trans_cmplt,
    output logic        dbus_trans_cmplt,
    output logic        ibus_acc_err,
    output logic        dbus_acc_err,
    output logic [31:0] ibus_data,
    output logic [31:0] dbus_data,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic        hlock,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    output logic        arb_idle
);

    ahb_req_t    w_ireq, w_dreq, w_wreq;
    owner_e      w_win_owner;
    logic        w_win_vld, w_nonseq, w_grnt, w_force_ibus;
    logic        w_dp_vld, w_err_block;
    logic        r_ap_hold, r_lock_hold;
    owner_e      r_ap_owner;
    logic [31:0] r_haddr;

    assign w_ireq = '{addr: ibus_addr, size: ibus_size, prot: ibus_prot, write: 1'b0};
    assign w_dreq = '{addr: dbus_addr, size: dbus_size, prot: dbus_prot, write: dbus_write};

    always_comb begin
        w_win_owner = OWNER_DBUS;
        w_win_vld   = 1'b0;
        if (r_ap_hold) begin
            w_win_owner = r_ap_owner;
            w_win_vld   = (r_ap_owner == OWNER_DBUS) ? dbus_req : ibus_req;
        end else if (r_lock_hold) begin
            w_win_vld   = dbus_req;
        end else if (w_force_ibus) begin
            w_win_owner = OWNER_IBUS;
            w_win_vld   = 1'b1;
        end else if (dbus_req) begin
            w_win_vld   = 1'b1;
        end else if (ibus_req) begin
            w_win_owner = OWNER_IBUS;
            w_win_vld   = 1'b1;
        end
    end

    assign w_wreq    = (w_win_owner == OWNER_DBUS) ? w_dreq : w_ireq;
    assign w_nonseq  = w_win_vld & ~w_err_block;
    assign w_grnt    = w_nonseq & hready;
    assign ibus_grnt = w_grnt & (w_win_owner == OWNER_IBUS);
    assign dbus_grnt = w_grnt & (w_win_owner == OWNER_DBUS);

    assign htrans = w_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr  = w_win_vld ? w_wreq.addr : r_haddr;
    assign hwrite = w_win_vld & w_wreq.write;
    assign hsize  = w_win_vld ? {1'b0, w_wreq.size} : 3'b000;
    assign hprot  = w_win_vld ? w_wreq.prot : 4'b0000;
    assign hburst = HBURST_SINGLE;
    assign hlock  = r_lock_hold | (w_win_vld & (w_win_owner == OWNER_DBUS) & dbus_lock);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_haddr     <= '0;
            r_ap_hold   <= 1'b0;
            r_ap_owner  <= OWNER_IBUS;
            r_lock_hold <= 1'b0;
        end else begin
            if (w_win_vld)
                r_haddr <= w_wreq.addr;
            // An ERROR response cancels a stalled address phase; the
            // requester re-arbitrates afterwards.
            if (w_err_block || w_grnt) begin
                r_ap_hold <= 1'b0;
            end else if (w_nonseq && !hready) begin
                r_ap_hold  <= 1'b1;
                r_ap_owner <= w_win_owner;
            end
            if (dbus_grnt)
                r_lock_hold <= dbus_lock;
            else if (!dbus_req && !w_dp_vld)
                r_lock_hold <= 1'b0;
        end
    end

`ifdef PA_SAHBL_ARB_STARVE_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    logic [2:0] r_starve_cnt;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            r_starve_cnt <= '0;
        else if (!ibus_req || ibus_grnt)
            r_starve_cnt <= '0;
        else if (dbus_grnt && r_starve_cnt != STARVE_LIM)
            r_starve_cnt <= r_starve_cnt + 3'd1;
    end

    assign w_force_ibus = ibus_req & (r_starve_cnt == STARVE_LIM);
`else
    assign w_force_ibus = 1'b0;
`endif

    pa_sahbl_arb_dp u_dp (
        .i_clk          (forever_cpuclk),
        .i_rst_n        (cpurst_b),
        .i_grnt         (w_grnt),
        .i_owner        (w_win_owner),
        .i_wr_load      (dbus_grnt & dbus_write),
        .i_wdata        (dbus_wdata),
        .i_hready       (hready),
        .i_hresp        (hresp),
        .o_dp_vld       (w_dp_vld),
        .o_err_block    (w_err_block),
        .o_hwdata       (hwdata),
        .o_ibus_cmplt   (ibus_trans_cmplt),
        .o_dbus_cmplt   (dbus_trans_cmplt),
        .o_ibus_acc_err (ibus_acc_err),
        .o_dbus_acc_err (dbus_acc_err)
    );

    assign ibus_data = hrdata;
    assign dbus_data = hrdata;
    assign arb_idle  = ~ibus_req & ~dbus_req & ~w_dp_vld;

endmodule

// File: tb/tb_pa_sahbl_arb.sv
// tb_pa_sahbl_arb: directed checks of pa_sahbl_arb with hand-computed
// expectations. Inputs change 1ns after the rising edge, outputs are
// sampled 1ns later, well away from the next edge.
module tb_pa_sahbl_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_req, dbus_req, dbus_write, dbus_lock;
    logic [31:0] ibus_addr, dbus_addr, dbus_wdata, hrdata;
    logic [1:0]  ibus_size, dbus_size;
    logic [3:0]  ibus_prot, dbus_prot;
    logic        hready, hresp;
    logic        ibus_grnt, dbus_grnt, ibus_trans_cmplt, dbus_trans_cmplt;
    logic        ibus_acc_err, dbus_acc_err, hwrite, hlock, arb_idle;
    logic [31:0] ibus_data, dbus_data, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pa_sahbl_arb #(.STARVE_MAX(4)) dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_size(ibus_size), .ibus_prot(ibus_prot),
        .dbus_req(dbus_req), .dbus_addr(dbus_addr), .dbus_size(dbus_size), .dbus_prot(dbus_prot),
        .dbus_write(dbus_write), .dbus_lock(dbus_lock), .dbus_wdata(dbus_wdata),
        .ibus_grnt(ibus_grnt), .dbus_grnt(dbus_grnt),
        .ibus_trans_cmplt(ibus_trans_cmplt), .dbus_trans_cmplt(dbus_trans_cmplt),
        .ibus_acc_err(ibus_acc_err), .dbus_acc_err(dbus_acc_err),
        .ibus_data(ibus_data), .dbus_data(dbus_data),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hlock(hlock), .hburst(hburst), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp), .arb_idle(arb_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int n_ig;
    int first_ig;

    initial begin
        rst_n = 1'b0;
        ibus_req = 0; dbus_req = 0; dbus_write = 0; dbus_lock = 0;
        ibus_addr = 0; dbus_addr = 0; dbus_wdata = 0; hrdata = 0;
        ibus_size = 2'd2; dbus_size = 2'd2; ibus_prot = 4'h3; dbus_prot = 4'h1;
        hready = 1; hresp = 0;
        #2;
        // reset state
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_hlock", 32'(hlock), 32'h0);
        chk("rst_grnt", 32'({ibus_grnt, dbus_grnt}), 32'h0);
        chk("rst_cmplt", 32'({ibus_trans_cmplt, dbus_trans_cmplt, ibus_acc_err, dbus_acc_err}), 32'h0);
        chk("rst_idle", 32'(arb_idle), 32'h1);
        chk("rst_hburst", 32'(hburst), 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // both request together: dbus first, ibus pipelined behind
        ibus_req = 1; ibus_addr = 32'h0000_0100;
        dbus_req = 1; dbus_addr = 32'h0000_0200;
        #1;
        chk("bb_c0_dgrnt", 32'(dbus_grnt), 32'h1);
        chk("bb_c0_igrnt", 32'(ibus_grnt), 32'h0);
        chk("bb_c0_haddr", haddr, 32'h0000_0200);
        chk("bb_c0_htrans", 32'(htrans), 32'h2);
        chk("bb_c0_hsize", 32'(hsize), 32'h2);
        cyc();
        dbus_req = 0; hrdata = 32'hA5A5_0001;
        #1;
        chk("bb_c1_dcmplt", 32'(dbus_trans_cmplt), 32'h1);
        chk("bb_c1_ddata", dbus_data, 32'hA5A5_0001);
        chk("bb_c1_igrnt", 32'(ibus_grnt), 32'h1);
        chk("bb_c1_haddr", haddr, 32'h0000_0100);
        chk("bb_c1_hprot", 32'(hprot), 32'h3);
        cyc();
        ibus_req = 0; hrdata = 32'h1234_5678;
        #1;
        chk("bb_c2_icmplt", 32'(ibus_trans_cmplt), 32'h1);
        chk("bb_c2_dcmplt", 32'(dbus_trans_cmplt), 32'h0);
        chk("bb_c2_idata", ibus_data, 32'h1234_5678);
        chk("bb_c2_htrans", 32'(htrans), 32'h0);
        chk("bb_c2_haddr_hold", haddr, 32'h0000_0100);
        cyc();
        #1;
        chk("bb_c3_idle", 32'(arb_idle), 32'h1);

        // dbus write, two wait states, ibus address stalls behind it
        cyc();
        dbus_req = 1; dbus_write = 1; dbus_addr = 32'h2000_0010; dbus_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_c0_grnt", 32'(dbus_grnt), 32'h1);
        chk("wr_c0_hwrite", 32'(hwrite), 32'h1);
        chk("wr_c0_haddr", haddr, 32'h2000_0010);
        cyc();
        dbus_req = 0; dbus_write = 0; dbus_wdata = 0; hready = 0;
        ibus_req = 1; ibus_addr = 32'h0000_0400;
        #1;
        chk("wr_c1_htrans", 32'(htrans), 32'h2);
        chk("wr_c1_hwdata", hwdata, 32'hDEAD_BEEF);
        chk("wr_c1_cmplt", 32'(dbus_trans_cmplt), 32'h0);
        chk("wr_c1_igrnt", 32'(ibus_grnt), 32'h0);
        cyc();
        // new dbus request must not steal the held ibus address phase
        dbus_req = 1; dbus_addr = 32'h0000_0500;
        #1;
        chk("wr_c2_htrans", 32'(htrans), 32'h2);
        chk("wr_c2_haddr", haddr, 32'h0000_0400);
        chk("wr_c2_cmplt", 32'(dbus_trans_cmplt), 32'h0);
        cyc();
        hready = 1;
        #1;
        chk("wr_c3_htrans", 32'(htrans), 32'h2);
        chk("wr_c3_hwdata", hwdata, 32'hDEAD_BEEF);
        chk("wr_c3_dcmplt", 32'(dbus_trans_cmplt), 32'h1);
        chk("wr_c3_igrnt", 32'(ibus_grnt), 32'h1);
        chk("wr_c3_dgrnt", 32'(dbus_grnt), 32'h0);
        cyc();
        ibus_req = 0;
        #1;
        chk("wr_c4_icmplt", 32'(ibus_trans_cmplt), 32'h1);
        chk("wr_c4_dgrnt", 32'(dbus_grnt), 32'h1);
        chk("wr_c4_haddr", haddr, 32'h0000_0500);
        cyc();
        dbus_req = 0;
        #1;
        chk("wr_c5_dcmplt", 32'(dbus_trans_cmplt), 32'h1);
        cyc();

        // continuous contention
        ibus_req = 1; dbus_req = 1; n_ig = 0; first_ig = -1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("stv_one_grnt", 32'(ibus_grnt ^ dbus_grnt), 32'h1);
            if (ibus_grnt) begin
                n_ig++;
                if (first_ig < 0) first_ig = k;
            end
            cyc();
        end
        ibus_req = 0; dbus_req = 0;
        #1;
        chk("stv_drain", 32'(dbus_trans_cmplt), 32'h1);
`ifdef PA_SAHBL_ARB_STARVE_EN
        chk("stv_n_ibus", 32'(n_ig), 32'd1);
        chk("stv_first_ibus", 32'(first_ig), 32'd4);
`else
        chk("stv_n_ibus", 32'(n_ig), 32'd0);
        chk("stv_first_ibus", 32'(first_ig), 32'hFFFF_FFFF);
`endif
        cyc();

        // ibus read answered with ERROR while dbus waits
        ibus_req = 1; ibus_addr = 32'h0000_0300;
        #1;
        chk("err_c0_igrnt", 32'(ibus_grnt), 32'h1);
        cyc();
        ibus_req = 0; dbus_req = 1; dbus_addr = 32'h0000_0600; hresp = 1; hready = 0;
        #1;
        chk("err_c1_htrans", 32'(htrans), 32'h0);
        chk("err_c1_dgrnt", 32'(dbus_grnt), 32'h0);
        chk("err_c1_icmplt", 32'(ibus_trans_cmplt), 32'h0);
        cyc();
        hready = 1;
        #1;
        chk("err_c2_htrans", 32'(htrans), 32'h0);
        chk("err_c2_dgrnt", 32'(dbus_grnt), 32'h0);
        chk("err_c2_icmplt", 32'(ibus_trans_cmplt), 32'h1);
        chk("err_c2_iaccerr", 32'(ibus_acc_err), 32'h1);
        chk("err_c2_daccerr", 32'(dbus_acc_err), 32'h0);
        cyc();
        hresp = 0;
        #1;
        chk("err_c3_dgrnt", 32'(dbus_grnt), 32'h1);
        chk("err_c3_haddr", haddr, 32'h0000_0600);
        cyc();
        dbus_req = 0;
        #1;
        chk("err_c4_dcmplt", 32'(dbus_trans_cmplt), 32'h1);
        chk("err_c4_daccerr", 32'(dbus_acc_err), 32'h0);
        cyc();

        // locked dbus sequence keeps ibus out
        ibus_req = 1; ibus_addr = 32'h0000_0700;
        dbus_req = 1; dbus_lock = 1; dbus_addr = 32'h0000_0800;
        #1;
        chk("lk_c0_dgrnt", 32'(dbus_grnt), 32'h1);
        chk("lk_c0_hlock", 32'(hlock), 32'h1);
        cyc();
        dbus_req = 0;
        #1;
        chk("lk_c1_igrnt", 32'(ibus_grnt), 32'h0);
        chk("lk_c1_hlock", 32'(hlock), 32'h1);
        chk("lk_c1_htrans", 32'(htrans), 32'h0);
        cyc();
        dbus_req = 1; dbus_addr = 32'h0000_0804;
        #1;
        chk("lk_c2_dgrnt", 32'(dbus_grnt), 32'h1);
        chk("lk_c2_igrnt", 32'(ibus_grnt), 32'h0);
        cyc();
        dbus_lock = 0; dbus_addr = 32'h0000_0808;
        #1;
        chk("lk_c3_dgrnt", 32'(dbus_grnt), 32'h1);
        chk("lk_c3_igrnt", 32'(ibus_grnt), 32'h0);
        chk("lk_c3_hlock", 32'(hlock), 32'h1);
        cyc();
        dbus_req = 0;
        #1;
        chk("lk_c4_igrnt", 32'(ibus_grnt), 32'h1);
        chk("lk_c4_hlock", 32'(hlock), 32'h0);
        cyc();
        ibus_req = 0;
        #1;
        chk("lk_c5_icmplt", 32'(ibus_trans_cmplt), 32'h1);
        cyc();

        // reset during a waited data phase
        dbus_req = 1; dbus_addr = 32'h0000_0900;
        #1;
        chk("rs_c0_dgrnt", 32'(dbus_grnt), 32'h1);
        cyc();
        dbus_req = 0; hready = 0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rs_htrans", 32'(htrans), 32'h0);
        chk("rs_haddr", haddr, 32'h0);
        chk("rs_hwdata", hwdata, 32'h0);
        chk("rs_idle", 32'(arb_idle), 32'h1);
        chk("rs_cmplt", 32'({ibus_trans_cmplt, dbus_trans_cmplt}), 32'h0);
        cyc();
        hready = 1;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rs_post_cmplt", 32'({ibus_trans_cmplt, dbus_trans_cmplt}), 32'h0);
        cyc();
        #1;
        chk("rs_post_cmplt2", 32'({ibus_trans_cmplt, dbus_trans_cmplt}), 32'h0);
        chk("rs_post_idle", 32'(arb_idle), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
